// File: rtl/noc_r_block_pkg.sv
// Shared NoC parameters: mesh size, coordinate width and the route direction encoding.
// NOC_DIAG_ROUTE_EN selects diagonal routing; otherwise XY dimension-order routing.
package global_params;

    localparam int MESH_SIDE = 3;
    localparam int CW        = $clog2(MESH_SIDE);

    typedef enum logic [3:0] {
        NORTH = 4'd0,
        EAST  = 4'd1,
        SOUTH = 4'd2,
        WEST  = 4'd3,
        LOCAL = 4'd4,
        NE    = 4'd5,
        NW    = 4'd6,
        SE    = 4'd7,
        SW    = 4'd8
    } dir_t;

    localparam int DIR_N  = 0;
    localparam int DIR_E  = 1;
    localparam int DIR_S  = 2;
    localparam int DIR_W  = 3;
    localparam int DIR_L  = 4;
    localparam int DIR_NE = 5;
    localparam int DIR_NW = 6;
    localparam int DIR_SE = 7;
    localparam int DIR_SW = 8;
    localparam int N_DIRS = 9;

    // Diagonal register bits are forced to constant zero in the XY build.
`ifdef NOC_DIAG_ROUTE_EN
    localparam logic [N_DIRS-1:0] DIAG_MASK = 9'h1FF;
`else
    localparam logic [N_DIRS-1:0] DIAG_MASK = 9'h01F;
`endif

endpackage

// File: rtl/noc_r_block_dir_decode.sv
// Combinational route decision from destination coordinates and delta sign bits.
// NOC_DIAG_ROUTE_EN selects diagonal routing; otherwise XY dimension-order, X first.
module r_dir_decode
    import global_params::*;
#(
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic [CW-1:0] dest_x,
    input  logic [CW-1:0] dest_y,
    input  logic          s_delta_x,
    input  logic          s_delta_y,
    output dir_t          dir
);

    logic zx;
    logic zy;

    // Equality wins over the sign bits, so a stale sign on a zero delta is harmless.
    assign zx = (dest_x == CW'(X_COORD));
    assign zy = (dest_y == CW'(Y_COORD));

    always_comb begin
        dir = LOCAL;
`ifdef NOC_DIAG_ROUTE_EN
        if (zx && zy) begin
            dir = LOCAL;
        end else if (zx) begin
            dir = s_delta_y ? SOUTH : NORTH;
        end else if (zy) begin
            dir = s_delta_x ? WEST : EAST;
        end else begin
            case ({s_delta_x, s_delta_y})
                2'b00:   dir = NE;
                2'b10:   dir = NW;
                2'b01:   dir = SE;
                default: dir = SW;
            endcase
        end
`else
        if (!zx) begin
            dir = s_delta_x ? WEST : EAST;
        end else if (!zy) begin
            dir = s_delta_y ? SOUTH : NORTH;
        end else begin
            dir = LOCAL;
        end
`endif
    end

endmodule

// File: rtl/noc_r_block.sv
// Per-router route computation: registered one-hot direction strobes, 1-cycle latency.
// NOC_DIAG_ROUTE_EN enables the four diagonal outputs; otherwise they stay 0.
module noc_r_block
    import global_params::*;
#(
    parameter int X_COORD = 0,
    parameter int Y_COORD = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] dest_x,
    input  logic [CW-1:0] dest_y,
    input  logic          s_delta_x,
    input  logic          s_delta_y,
    input  logic          valid,
    output logic          route_north,
    output logic          route_east,
    output logic          route_south,
    output logic          route_west,
    output logic          route_local,
    output logic          route_ne,
    output logic          route_nw,
    output logic          route_se,
    output logic          route_sw
);

    dir_t              dir_p0;
    logic [N_DIRS-1:0] route_p0;
    logic [N_DIRS-1:0] route_p1;

    r_dir_decode #(
        .X_COORD (X_COORD),
        .Y_COORD (Y_COORD)
    ) u_dir_decode (
        .dest_x    (dest_x),
        .dest_y    (dest_y),
        .s_delta_x (s_delta_x),
        .s_delta_y (s_delta_y),
        .dir       (dir_p0)
    );

    always_comb begin
        route_p0 = '0;
        if (valid) begin
            route_p0 = (N_DIRS'(1) << dir_p0) & DIAG_MASK;
        end
    end

    // Stage p0 -> p1: decision register feeding the switch allocator.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            route_p1 <= '0;
        end else begin
            route_p1 <= route_p0;
        end
    end

    assign route_north = route_p1[DIR_N];
    assign route_east  = route_p1[DIR_E];
    assign route_south = route_p1[DIR_S];
    assign route_west  = route_p1[DIR_W];
    assign route_local = route_p1[DIR_L];
    assign route_ne    = route_p1[DIR_NE];
    assign route_nw    = route_p1[DIR_NW];
    assign route_se    = route_p1[DIR_SE];
    assign route_sw    = route_p1[DIR_SW];

`ifndef SYNTHESIS
    a_route_onehot0: assert property (@(posedge clk) $onehot0(route_p1));
`endif

endmodule

// File: tb/tb_noc_r_block.sv
// Scoreboard bench for noc_r_block at router (1,1) of a 3x3 mesh; expectations cover both builds.
module tb_noc_r_block;
    import global_params::*;

    localparam logic [8:0] O_N  = 9'h001;
    localparam logic [8:0] O_E  = 9'h002;
    localparam logic [8:0] O_S  = 9'h004;
    localparam logic [8:0] O_W  = 9'h008;
    localparam logic [8:0] O_L  = 9'h010;
    localparam logic [8:0] O_NE = 9'h020;
    localparam logic [8:0] O_NW = 9'h040;
    localparam logic [8:0] O_SE = 9'h080;
    localparam logic [8:0] O_SW = 9'h100;

    typedef struct {
        logic [CW-1:0] dx;
        logic [CW-1:0] dy;
        logic          sdx;
        logic          sdy;
        logic [8:0]    exp_diag;
        logic [8:0]    exp_xy;
    } vec_t;

    typedef struct {
        logic [8:0] exp;
        int         tag;
    } sb_t;

    logic          clk;
    logic          rst;
    logic [CW-1:0] dest_x;
    logic [CW-1:0] dest_y;
    logic          s_delta_x;
    logic          s_delta_y;
    logic          valid;
    logic          route_north, route_east, route_south, route_west, route_local;
    logic          route_ne, route_nw, route_se, route_sw;
    logic [8:0]    outs;

    int checks;
    int failures;
    sb_t sb_q[$];
    vec_t vecs[$];

    noc_r_block #(
        .X_COORD (1),
        .Y_COORD (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .dest_x      (dest_x),
        .dest_y      (dest_y),
        .s_delta_x   (s_delta_x),
        .s_delta_y   (s_delta_y),
        .valid       (valid),
        .route_north (route_north),
        .route_east  (route_east),
        .route_south (route_south),
        .route_west  (route_west),
        .route_local (route_local),
        .route_ne    (route_ne),
        .route_nw    (route_nw),
        .route_se    (route_se),
        .route_sw    (route_sw)
    );

    assign outs = {route_sw, route_se, route_nw, route_ne, route_local,
                   route_west, route_south, route_east, route_north};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [8:0] pick(input vec_t v);
`ifdef NOC_DIAG_ROUTE_EN
        return v.exp_diag;
`else
        return v.exp_xy;
`endif
    endfunction

    task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b", name, act, req);
        end
    endtask

    // Drive one vector at the falling edge and queue its expected response.
    task automatic apply(input vec_t v, input logic vld, input int tag);
        @(negedge clk);
        dest_x    = v.dx;
        dest_y    = v.dy;
        s_delta_x = v.sdx;
        s_delta_y = v.sdy;
        valid     = vld;
        sb_q.push_back('{exp: (vld ? pick(v) : 9'h000), tag: tag});
    endtask

    // Monitor: an entry queued before this edge must be visible just after it.
    initial begin
        sb_t e;
        forever begin
            @(posedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                #1;
                check($sformatf("route[%0d]", e.tag), outs, e.exp);
            end
        end
    end

    initial begin
        vec_t v;
        int   wait_cyc;
        checks   = 0;
        failures = 0;
        rst       = 1'b1;
        dest_x    = '0;
        dest_y    = '0;
        s_delta_x = 1'b0;
        s_delta_y = 1'b0;
        valid     = 1'b0;

        // Sweep order: local, N, S, E, W, NE, NW, SE, SW.
        vecs.push_back('{2'd1, 2'd1, 1'b0, 1'b0, O_L,  O_L});
        vecs.push_back('{2'd1, 2'd2, 1'b0, 1'b0, O_N,  O_N});
        vecs.push_back('{2'd1, 2'd0, 1'b0, 1'b1, O_S,  O_S});
        vecs.push_back('{2'd2, 2'd1, 1'b0, 1'b0, O_E,  O_E});
        vecs.push_back('{2'd0, 2'd1, 1'b1, 1'b0, O_W,  O_W});
        vecs.push_back('{2'd2, 2'd2, 1'b0, 1'b0, O_NE, O_E});
        vecs.push_back('{2'd0, 2'd2, 1'b1, 1'b0, O_NW, O_W});
        vecs.push_back('{2'd2, 2'd0, 1'b0, 1'b1, O_SE, O_E});
        vecs.push_back('{2'd0, 2'd0, 1'b1, 1'b1, O_SW, O_W});

        #2;
        check("reset_state", outs, 9'h000);
        @(posedge clk);
        #1;
        check("reset_held", outs, 9'h000);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b1, i);
        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], 1'b0, 100 + i);

        v = '{2'd1, 2'd1, 1'b1, 1'b1, O_L, O_L};
        apply(v, 1'b1, 200);
        v = '{2'd2, 2'd1, 1'b1, 1'b0, O_W, O_W};
        apply(v, 1'b1, 201);
        v = '{2'd3, 2'd1, 1'b0, 1'b0, O_E, O_E};
        apply(v, 1'b1, 202);
        v = '{2'd1, 2'd3, 1'b0, 1'b0, O_N, O_N};
        apply(v, 1'b1, 203);

        // Back-to-back with valid toggling: no stale or held decisions.
        apply(vecs[5], 1'b1, 300);
        apply(vecs[8], 1'b0, 301);
        apply(vecs[8], 1'b1, 302);
        apply(vecs[1], 1'b1, 303);
        apply(vecs[6], 1'b1, 304);

        // Mid-stream reset while the NE decision is on the outputs.
        apply(vecs[5], 1'b1, 400);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("rst_async_drop", outs, 9'h000);
        @(negedge clk);
        dest_x = 2'd0; dest_y = 2'd2; s_delta_x = 1'b1; s_delta_y = 1'b0; valid = 1'b1;
        @(posedge clk);
        #1;
        check("rst_held_edge", outs, 9'h000);
        @(negedge clk);
        rst = 1'b0;
        dest_x = 2'd2; dest_y = 2'd0; s_delta_x = 1'b0; s_delta_y = 1'b1; valid = 1'b1;
        sb_q.push_back('{exp: pick(vecs[7]), tag: 401});
        apply(vecs[0], 1'b1, 402);
        apply(vecs[0], 1'b0, 403);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(posedge clk);
            wait_cyc++;
        end
        @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/noc_r_block.md
# noc_r_block

Per-router route-computation block for the synchronous 2D mesh NoC with diagonal links. From a flit header's destination coordinates and delta sign bits it selects exactly one of nine output directions: N, E, S, W, Local, NE, NW, SE or SW. The selection is registered so it is ready for the switch allocator on the next cycle. One instance sits in each router, parameterised with that router's own mesh coordinates.

## Interface
Parameters:
- X_COORD, default 0, column of this router (0..MESH_SIDE-1).
- Y_COORD, default 0, row of this router (0..MESH_SIDE-1).

Ports (CW = $clog2(MESH_SIDE)):
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- dest_x  in  CW  destination column.
- dest_y  in  CW  destination row.
- s_delta_x  in  1  sign of (dest_x - X_COORD); 1 = negative (westward).
- s_delta_y  in  1  sign of (dest_y - Y_COORD); 1 = negative (southward).
- valid  in  1  header present; request routing this cycle.
- route_north, route_east, route_south, route_west, route_local  out  1 each  registered direction strobes.
- route_ne, route_nw, route_se, route_sw  out  1 each  registered diagonal strobes.

## Operation
- Zero detect: zx = (dest_x == X_COORD), zy = (dest_y == Y_COORD). Zero detect takes priority over the sign bits. If a coordinate is equal and its sign bit is 1, the sign bit is ignored.
- Direction conventions:
  - East = +x, West = -x.
  - North = +y, South = -y.
  - Sign bit 0 with non-zero delta means positive.
- Decision, with diagonals enabled:
  - zx & zy -> local.
  - zx only -> north (sdy=0) or south (sdy=1).
  - zy only -> east (sdx=0) or west (sdx=1).
  - Both non-zero -> NE (0,0), NW (1,0), SE (0,1), SW (1,1), given as (sdx,sdy).
- valid=0 -> all nine next-state bits are 0.
- Outputs are one-hot when valid=1, and all-zero otherwise. No out-of-range checking: dest ≥ MESH_SIDE is treated arithmetically like any other value.

## Timing
- Outputs are registered. Latency is 1 cycle: inputs sampled at rising edge n appear on the outputs after edge n, and are held until edge n+1.
- No handshake or back-pressure. A new decision is made every cycle, and valid is re-evaluated each cycle.
- Reset asserted: all nine outputs go to 0 immediately, independent of clk. They stay 0 while rst=1.
- Reset released: the first decision appears after the first rising edge at which rst=0.
- Reset asserted mid-stream: the in-flight decision is discarded and no retry is made.
- Inputs change simultaneously with the edge: the value sampled at setup is the one used. There is no combinational path from input to output.

## Configuration
- Macro: NOC_DIAG_ROUTE_EN.
- Defined: the diagonal routing described above.
- Undefined: XY dimension-order routing, X first.
  - !zx -> east/west by sdx.
  - zx & !zy -> north/south by sdy.
  - zx & zy -> local.
  - route_ne/nw/se/sw are tied to 0, including during reset.
- All ports exist in both builds.

## Structure
- Shared package global_params holds:
  - MESH_SIDE (default 3), the single source of CW.
  - A direction enum dir_t (NORTH, EAST, SOUTH, WEST, LOCAL, NE, NW, SE, SW) and its index constants.
- Natural sub-module: r_dir_decode, purely combinational. It computes dir_t from the dest and sign inputs. The top holds a 9-bit register and drives the one-hot outputs from it.
- Include an assertion, under a simulation-only guard, that the outputs are one-hot or zero every cycle.

## Test plan
All scenarios use MESH_SIDE=3, X_COORD=Y_COORD=1, NOC_DIAG_ROUTE_EN defined, and valid=1 unless stated. Sign bits are set consistently: sdx = dest_x<1, sdy = dest_y<1.
- Sweep all 9 destinations: (1,1) -> local, (1,2) -> north, (1,0) -> south, (2,1) -> east, (0,1) -> west, (2,2) -> NE, (0,2) -> NW, (2,0) -> SE, (0,0) -> SW. Each appears exactly 1 cycle after being applied.
- Repeat the sweep with valid=0: all nine outputs are 0 every cycle.
- Inconsistent signs, dest (1,1) with sdx=sdy=1 -> local only.
- Assert rst mid-sweep while route_ne=1: all outputs drop to 0 before the next edge. Release rst: the following edge restores correct routing.
- Build without NOC_DIAG_ROUTE_EN: dest (2,2) -> east, (0,0) -> west, (1,0) -> south; diagonal outputs stay 0.
- Back-to-back destinations every cycle: outputs follow with exactly 1-cycle lag, with no stale or multi-hot cycles.
